rpc2_ctrl_wdat_arbiter: RTL and testbench
=========================================

# rpc2_ctrl_wdat_arbiter

Round-robin burst arbiter that shares the single write port of the controller's synchronous write-data FIFO between `NUM_REQ` upstream beat streams (AXI write-data paths). A requester is granted for a whole burst and holds the FIFO write port until its last beat is accepted. Per-burst completion is reported (requester ID and beat count) to the command sequencer so it can match FIFO contents to transactions. The block sits between the AXI slave write-data channels and the write-data FIFO input.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `DATA_WIDTH`, 16, beat width; equals the FIFO data width
- `LEN_BITS`, 8, beat counter width; maximum burst is 2^LEN_BITS beats
- `ID_BITS`, 3, width of the granted-requester index

- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester beat valid
- `req_last`  in  NUM_REQ  per-requester last beat of burst
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-requester beat accepted when valid&ready
- `fifo_full`  in  1  registered full from the write-data FIFO
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data
- `busy`  out  1  a burst is granted
- `grant_id`  out  ID_BITS  index of the current or last granted requester
- `burst_done`  out  1  one-cycle pulse when a burst ends
- `burst_beats`  out  LEN_BITS+1  beats in the ended burst; valid with `burst_done`
- `burst_err`  out  1  one-cycle pulse when a burst was cut at the maximum length

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held for `grant_id`.
- IDLE:
  - If any `req_valid` is high, the round-robin pick is registered into `grant_id` and the state goes to BUSY.
  - The pick is the first set requester at or after `rr_ptr`, searching upward with wrap.
  - No beat is accepted in IDLE.
- BUSY:
  - `req_ready[grant_id] = ~fifo_full`. All other readies are 0.
  - `fifo_wr_en = req_valid[grant_id] & ~fifo_full`.
  - `fifo_wr_data` is muxed from the granted slice.
  - `beat_cnt` increments on each accepted beat.
- Burst end, when an accepted beat has `req_last` = 1:
  - `burst_done` pulses with `burst_beats` = `beat_cnt` + 1.
  - `rr_ptr` = `grant_id` + 1, modulo NUM_REQ.
  - State returns to IDLE and `beat_cnt` clears.
- Overlength:
  - An accepted beat that would be beat 2^LEN_BITS without `req_last` ends the burst as above, and `burst_err` also pulses.
  - Remaining beats of that requester arbitrate as a new burst.
- No preemption: other requesters wait regardless of priority.
- `req_valid` dropping mid-burst stalls the port; the grant is held.
- Reset values:
  - State IDLE; `rr_ptr` 0; `grant_id` 0; `beat_cnt` 0.
  - All `req_ready` 0, `fifo_wr_en` 0, `busy` 0, `burst_done` 0, `burst_err` 0, `burst_beats` 0.
  - `fifo_wr_data` is 0 whenever not BUSY.
- Reset mid-burst: the burst is dropped immediately and no `burst_done` is issued. Beats already written stay in the FIFO; the FIFO is reset on the same `rst_n`.

## Timing
- One-cycle arbitration bubble: first valid in IDLE at cycle N, first beat accepted earliest at cycle N+1.
- Steady state is one beat per cycle while `fifo_full` = 0.
- `req_ready` and `fifo_wr_en` are combinational from `fifo_full`, state and `req_valid`. There is no dependence on FIFO `pre_full`, which avoids a combinational loop.
- `burst_done`, `burst_beats` and `burst_err` are registered. They are high in the cycle after the last beat is accepted, which is the same cycle the state reads IDLE.
- Back-to-back bursts:
  - The last beat is accepted at cycle N.
  - The next grant is registered at N+1.
  - The next beat is accepted at N+2.

## Structure
- Shared package `rpc2_ctrl_pkg` holds:
  - the state encoding (IDLE=1'b0, BUSY=1'b1);
  - the `ARB_MAX_REQ` = 8 constant.
- Sub-module `rpc2_ctrl_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `pick_id` and `pick_vld`.
  - It is reusable by the read-data return path.

## Test plan
- Single requester 0, 4-beat burst 0x11..0x44, FIFO never full:
  - 4 FIFO writes on consecutive cycles, starting one cycle after valid.
  - `burst_done` with `burst_beats` = 4 and `grant_id` = 0.
- Both requesters valid continuously with 2-beat bursts:
  - grant order 0,1,0,1.
  - Exactly one idle cycle between bursts.
  - FIFO data never interleaves within a burst.
- `fifo_full` forced high for 3 cycles mid-burst:
  - `req_ready` and `fifo_wr_en` are low during those 3 cycles.
  - No beat is lost or duplicated.
  - `burst_beats` is still correct.
- LEN_BITS=2, 6-beat burst without `req_last` until beat 6:
  - `burst_err` + `burst_done` with `burst_beats` = 4 after beat 4.
  - Then a new grant and `burst_done` with `burst_beats` = 2.
- `rst_n` asserted after 2 beats of a 4-beat burst:
  - all outputs are at reset values immediately;
  - after release, requester 0 is served first because `rr_ptr` = 0.

Source files
------------

// File: rtl/rpc2_ctrl_pkg.sv
// Shared controller types: arbiter state encoding and requester limit.
package rpc2_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/rpc2_ctrl_wdat_arbiter_if.sv
// Requester beat streams plus the write-data FIFO write port.
interface rpc2_ctrl_wdat_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

  // Requesters + FIFO side
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/rpc2_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rpc2_ctrl_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_BITS = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_BITS-1:0] ptr_i,
  output logic [ID_BITS-1:0] pick_id_o,
  output logic               pick_vld_o
);

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    int idx;
    pick_vld_o = |req_i;
    pick_id_o  = '0;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) pick_id_o = ID_BITS'(idx);
    end
  end

endmodule

// File: rtl/rpc2_ctrl_wdat_arbiter.sv
// Burst-granular round-robin arbiter onto the write-data FIFO write port.
module rpc2_ctrl_wdat_arbiter
  import rpc2_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_BITS   = 8,
  parameter int ID_BITS    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  rpc2_ctrl_wdat_arbiter_if.slave bus,
  output logic                busy_o,
  output logic [ID_BITS-1:0]  grant_id_o,
  output logic                burst_done_o,
  output logic [LEN_BITS:0]   burst_beats_o,
  output logic                burst_err_o
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
    $error("rpc2_ctrl_wdat_arbiter: NUM_REQ out of range");
  end

  arb_state_e            state_q, state_d;
  logic [ID_BITS-1:0]    grant_q, grant_d;
  logic [ID_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LEN_BITS-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  done_q, err_q;
  logic [LEN_BITS:0]     beats_q;

  logic [ID_BITS-1:0]    pick_id;
  logic                  pick_vld;
  logic [NUM_REQ-1:0]    g_sel;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  busy, accept, at_max, end_burst, cut_burst;

  rpc2_ctrl_rr_pick #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) u_pick (
    .req_i      (bus.req_valid),
    .ptr_i      (rr_ptr_q),
    .pick_id_o  (pick_id),
    .pick_vld_o (pick_vld)
  );

  // Select the granted requester's valid/last/data slice.
  always_comb begin
    g_sel   = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_BITS'(i)) begin
        g_sel[i] = 1'b1;
        g_valid  = bus.req_valid[i];
        g_last   = bus.req_last[i];
        g_data   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A beat whose count reaches 2^LEN_BITS closes the burst even without last.
  assign busy      = (state_q == ST_BUSY);
  assign accept    = busy & g_valid & ~bus.fifo_full;
  assign at_max    = &beat_cnt_q;
  assign end_burst = accept & (g_last | at_max);
  assign cut_burst = accept & ~g_last & at_max;

  assign bus.req_ready    = (busy && !bus.fifo_full) ? g_sel : '0;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = busy ? g_data : '0;

  // Next-state: grant in IDLE, count beats and release on burst end in BUSY.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          grant_d = pick_id;
        end
      end
      ST_BUSY: begin
        if (end_burst) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_q == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Registered completion report; beat count holds until the next burst end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      done_q <= end_burst;
      err_q  <= cut_burst;
      if (end_burst) beats_q <= {1'b0, beat_cnt_q} + 1'b1;
    end
  end

  assign busy_o        = busy;
  assign grant_id_o    = grant_q;
  assign burst_done_o  = done_q;
  assign burst_beats_o = beats_q;
  assign burst_err_o   = err_q;

endmodule

// File: tb/tb_rpc2_ctrl_wdat_arbiter.sv
// Directed vectors for the write-data arbiter (LEN_BITS=2 so overlength is reachable).
module tb_rpc2_ctrl_wdat_arbiter;
  localparam int NR = 2;
  localparam int DW = 16;
  localparam int LB = 2;
  localparam int IB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic            busy;
  logic [IB-1:0]   gid;
  logic            done;
  logic [LB:0]     beats;
  logic            err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rpc2_ctrl_wdat_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  rpc2_ctrl_wdat_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_BITS(LB), .ID_BITS(IB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .busy_o        (busy),
    .grant_id_o    (gid),
    .burst_done_o  (done),
    .burst_beats_o (beats),
    .burst_err_o   (err)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    v, l;
    logic [15:0]   d0, d1;
    logic          f;
    logic [1:0]    e_rdy;
    logic          e_we;
    logic [15:0]   e_wd;
    logic          e_busy;
    logic [2:0]    e_gid;
    logic          e_done;
    logic [2:0]    e_beats;
    logic          e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rs, input logic [1:0] v, input logic [1:0] l,
                     input logic [15:0] d0, input logic [15:0] d1, input logic f,
                     input logic [1:0] rdy, input logic we, input logic [15:0] wd,
                     input logic bz, input logic [2:0] g, input logic dn,
                     input logic [2:0] bt, input logic er);
    vec_t t;
    t.rst = rs; t.v = v; t.l = l; t.d0 = d0; t.d1 = d1; t.f = f;
    t.e_rdy = rdy; t.e_we = we; t.e_wd = wd; t.e_busy = bz; t.e_gid = g;
    t.e_done = dn; t.e_beats = bt; t.e_err = er;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [15:0] d0, input logic [15:0] d1, input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = {d1, d0};
    bus.fifo_full = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [1:0] rdy, input logic we,
                         input logic [15:0] wd, input logic bz, input logic [2:0] g,
                         input logic dn, input logic er);
    chk({nm, " rdy"},  32'(bus.req_ready),    32'(rdy));
    chk({nm, " we"},   32'(bus.fifo_wr_en),   32'(we));
    chk({nm, " wd"},   32'(bus.fifo_wr_data), 32'(wd));
    chk({nm, " busy"}, 32'(busy),             32'(bz));
    chk({nm, " gid"},  32'(gid),              32'(g));
    chk({nm, " done"}, 32'(done),             32'(dn));
    chk({nm, " err"},  32'(err),              32'(er));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b0);
    #2;
    chk_all("por", 2'b00, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("por beats", 32'(beats), 32'd0);
    tick; tick;
    rst_n = 1'b1;

    // Single requester 0, 4-beat burst
    add(0,2'd1,2'd0,16'h11,16'h0,0, 2'd0,0,16'h0, 0,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'h11,16'h0,0, 2'd1,1,16'h11,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'h22,16'h0,0, 2'd1,1,16'h22,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'h33,16'h0,0, 2'd1,1,16'h33,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd1,16'h44,16'h0,0, 2'd1,1,16'h44,1,3'd0,0,3'd0,0);
    add(0,2'd0,2'd0,16'h0, 16'h0,0, 2'd0,0,16'h0, 0,3'd0,1,3'd4,0);
    add(1,2'd0,2'd0,16'h0, 16'h0,0, 2'd0,0,16'h0, 0,3'd0,0,3'd0,0);
    // Both requesters, 2-beat bursts: grant order 0,1,0,1
    add(0,2'd3,2'd0,16'hA1,16'hB1,0, 2'd0,0,16'h0, 0,3'd0,0,3'd0,0);
    add(0,2'd3,2'd0,16'hA1,16'hB1,0, 2'd1,1,16'hA1,1,3'd0,0,3'd0,0);
    add(0,2'd3,2'd1,16'hA2,16'hB1,0, 2'd1,1,16'hA2,1,3'd0,0,3'd0,0);
    add(0,2'd3,2'd0,16'hA3,16'hB1,0, 2'd0,0,16'h0, 0,3'd0,1,3'd2,0);
    add(0,2'd3,2'd0,16'hA3,16'hB1,0, 2'd2,1,16'hB1,1,3'd1,0,3'd0,0);
    add(0,2'd3,2'd2,16'hA3,16'hB2,0, 2'd2,1,16'hB2,1,3'd1,0,3'd0,0);
    add(0,2'd3,2'd0,16'hA3,16'hB3,0, 2'd0,0,16'h0, 0,3'd1,1,3'd2,0);
    add(0,2'd3,2'd0,16'hA3,16'hB3,0, 2'd1,1,16'hA3,1,3'd0,0,3'd0,0);
    add(0,2'd3,2'd1,16'hA4,16'hB3,0, 2'd1,1,16'hA4,1,3'd0,0,3'd0,0);
    add(0,2'd3,2'd0,16'hA5,16'hB3,0, 2'd0,0,16'h0, 0,3'd0,1,3'd2,0);
    add(0,2'd3,2'd0,16'hA5,16'hB3,0, 2'd2,1,16'hB3,1,3'd1,0,3'd0,0);
    add(0,2'd3,2'd2,16'hA5,16'hB4,0, 2'd2,1,16'hB4,1,3'd1,0,3'd0,0);
    add(0,2'd0,2'd0,16'h0, 16'h0, 0, 2'd0,0,16'h0, 0,3'd1,1,3'd2,0);
    // fifo_full for 3 cycles mid-burst
    add(0,2'd1,2'd0,16'hC1,16'h0,0, 2'd0,0,16'h0, 0,3'd1,0,3'd0,0);
    add(0,2'd1,2'd0,16'hC1,16'h0,0, 2'd1,1,16'hC1,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'hC2,16'h0,0, 2'd1,1,16'hC2,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'hC3,16'h0,1, 2'd0,0,16'hC3,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'hC3,16'h0,1, 2'd0,0,16'hC3,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'hC3,16'h0,1, 2'd0,0,16'hC3,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd0,16'hC3,16'h0,0, 2'd1,1,16'hC3,1,3'd0,0,3'd0,0);
    add(0,2'd1,2'd1,16'hC4,16'h0,0, 2'd1,1,16'hC4,1,3'd0,0,3'd0,0);
    add(0,2'd0,2'd0,16'h0, 16'h0,0, 2'd0,0,16'h0, 0,3'd0,1,3'd4,0);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t t;
      string nm;
      t = vq[i];
      nm = $sformatf("v%0d", i);
      rst_n = ~t.rst;
      drive(t.v, t.l, t.d0, t.d1, t.f);
      #2;
      chk_all(nm, t.e_rdy, t.e_we, t.e_wd, t.e_busy, t.e_gid, t.e_done, t.e_err);
      if (t.e_done) chk({nm, " beats"}, 32'(beats), 32'(t.e_beats));
      tick;
    end
    rst_n = 1'b1;

    // Overlength: requester 1 sends 6 beats, last only on beat 6 (rr_ptr is 1)
    drive(2'b10, 2'b00, 16'h0, 16'hD1, 1'b0); #2;
    chk_all("ovl idle", 2'b00, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick;
    for (int k = 1; k <= 4; k++) begin
      drive(2'b10, 2'b00, 16'h0, 16'hD0 + 16'(k), 1'b0); #2;
      chk_all($sformatf("ovl b%0d", k), 2'b10, 1'b1, 16'hD0 + 16'(k), 1'b1, 3'd1, 1'b0, 1'b0);
      tick;
    end
    drive(2'b10, 2'b00, 16'h0, 16'hD5, 1'b0); #2;
    chk_all("ovl cut", 2'b00, 1'b0, 16'h0, 1'b0, 3'd1, 1'b1, 1'b1);
    chk("ovl cut beats", 32'(beats), 32'd4);
    tick;
    drive(2'b10, 2'b00, 16'h0, 16'hD5, 1'b0); #2;
    chk_all("ovl b5", 2'b10, 1'b1, 16'hD5, 1'b1, 3'd1, 1'b0, 1'b0);
    tick;
    drive(2'b10, 2'b10, 16'h0, 16'hD6, 1'b0); #2;
    chk_all("ovl b6", 2'b10, 1'b1, 16'hD6, 1'b1, 3'd1, 1'b0, 1'b0);
    tick;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b0); #2;
    chk_all("ovl end", 2'b00, 1'b0, 16'h0, 1'b0, 3'd1, 1'b1, 1'b0);
    chk("ovl end beats", 32'(beats), 32'd2);
    tick;

    // Reset mid-burst: 1-beat burst by req 0 moves rr_ptr to 1, then cut req 1's burst
    drive(2'b01, 2'b01, 16'hE0, 16'h0, 1'b0); tick;
    drive(2'b01, 2'b01, 16'hE0, 16'h0, 1'b0); #2;
    chk("rst e0 wd", 32'(bus.fifo_wr_data), 32'h00E0);
    tick;
    drive(2'b10, 2'b00, 16'h0, 16'hF1, 1'b0); #2;
    chk("rst e0 done", 32'(done), 32'd1);
    chk("rst e0 beats", 32'(beats), 32'd1);
    tick;
    drive(2'b10, 2'b00, 16'h0, 16'hF1, 1'b0); #2;
    chk("rst f1 gid", 32'(gid), 32'd1);
    chk("rst f1 we", 32'(bus.fifo_wr_en), 32'd1);
    tick;
    drive(2'b10, 2'b00, 16'h0, 16'hF2, 1'b0); tick;
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 16'h61, 16'hF3, 1'b0); #2;
    chk_all("rst now", 2'b00, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("rst now beats", 32'(beats), 32'd0);
    tick;
    rst_n = 1'b1; #2;
    chk_all("rst rel", 2'b00, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick; #2;
    chk_all("rst regrant", 2'b01, 1'b1, 16'h61, 1'b1, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
